bitstream_loader: RTL and testbench

BITSTREAM_LOADER -- requirements
Module: bitstream_loader

---
 rtl/bitstream_loader.sv | 189 ++++++++++++++++++
 tb/tb_bitstream_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_loader.sv
// Configuration bitstream loader: hunts for a sync byte, packs little-endian
// 32-bit words into configuration memory and validates a trailing XOR checksum.
module bitstream_loader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 1357,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                xfer_s;
  logic                start_s;
  logic                data_xfer_s;
  logic                word_end_s;
  logic [ADDR_W-1:0]   word_cnt_r;
  logic [1:0]          byte_idx_r;
  logic [7:0]          csum_r;
  logic [23:0]         word_r;
  logic                byte_ready_r;
  logic                busy_r;
  logic                done_r;
  logic                error_r;
  logic                bram_we_r;
  logic [ADDR_W-1:0]   bram_addr_r;
  logic [31:0]         bram_din_r;

  assign xfer_s = byte_valid & byte_ready_r;

  // State register
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    data_xfer_s = 1'b0;
    word_end_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_nxt_s = ST_SYNC;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SYNC: begin
        if (xfer_s && (byte_data == SYNC)) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          data_xfer_s = 1'b1;
          if (byte_idx_r == 2'd3) begin
            word_end_s = 1'b1;
            if (word_cnt_r == LAST_ADDR) begin
              state_nxt_s = ST_CHECK;
            end else begin
              state_nxt_s = ST_DATA;
            end
          end else begin
            word_end_s = 1'b0;
          end
        end else begin
          data_xfer_s = 1'b0;
        end
      end
      ST_CHECK: begin
        if (xfer_s) begin
          if (byte_data == csum_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      byte_ready_r <= (state_nxt_s == ST_SYNC) || (state_nxt_s == ST_DATA) || (state_nxt_s == ST_CHECK);
      busy_r       <= (state_nxt_s == ST_SYNC) || (state_nxt_s == ST_DATA) || (state_nxt_s == ST_CHECK);
      done_r       <= (state_nxt_s == ST_DONE);
      error_r      <= (state_nxt_s == ST_ERR);
    end
  end

  // Word assembly, checksum and memory write port
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      word_cnt_r  <= '0;
      byte_idx_r  <= 2'd0;
      csum_r      <= 8'h00;
      word_r      <= 24'h000000;
      bram_we_r   <= 1'b0;
      bram_addr_r <= '0;
      bram_din_r  <= 32'h0000_0000;
    end else begin
      bram_we_r <= 1'b0;
      if (start_s) begin
        word_cnt_r <= '0;
        byte_idx_r <= 2'd0;
        csum_r     <= 8'h00;
        word_r     <= 24'h000000;
      end else if (data_xfer_s) begin
        csum_r     <= csum_update(csum_r, byte_data);
        byte_idx_r <= byte_idx_r + 2'd1;
        if (word_end_s) begin
          bram_we_r   <= 1'b1;
          bram_addr_r <= word_cnt_r;
          bram_din_r  <= {byte_data, word_r};
          // Saturate on the last word so the index never wraps
          if (word_cnt_r != LAST_ADDR) begin
            word_cnt_r <= word_cnt_r + ADDR_W'(1);
          end else begin
            word_cnt_r <= word_cnt_r;
          end
        end else begin
          case (byte_idx_r)
            2'd0:    word_r[7:0]   <= byte_data;
            2'd1:    word_r[15:8]  <= byte_data;
            2'd2:    word_r[23:16] <= byte_data;
            default: word_r        <= word_r;
          endcase
        end
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign bram_we    = bram_we_r;
  assign bram_addr  = bram_addr_r;
  assign bram_din   = bram_din_r;

endmodule

// File: tb/tb_bitstream_loader.sv
// Bench for bitstream_loader (DEPTH=4): a byte-level reference model checked every
// cycle, plus literal expectations on write logs and final status.
module tb_bitstream_loader;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;
  localparam int M_IDLE = 0, M_SYNC = 1, M_DATA = 2, M_CHECK = 3, M_DONE = 4, M_ERR = 5;
  localparam logic [31:0] EXP_W [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  logic              clk = 1'b0;
  logic              nres = 1'b0;
  logic              load_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, bram_we, busy, done, error;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int                m_mode = M_IDLE;
  logic [7:0]        m_csum = 8'h00;
  logic [7:0]        m_buf[$];
  int                m_words = 0;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_din = 32'h0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_din[$];

  bitstream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC(8'hA5)) dut (
    .clk(clk), .nres(nres), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit accepting(input int m);
    return (m == M_SYNC) || (m == M_DATA) || (m == M_CHECK);
  endfunction

  task automatic model_step();
    bit xfer;
    if (!nres) begin
      m_mode = M_IDLE; m_csum = 8'h00; m_buf.delete(); m_words = 0;
      m_we = 1'b0; m_addr = '0; m_din = 32'h0;
    end else begin
      xfer = byte_valid && accepting(m_mode);
      m_we = 1'b0;
      if (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_ERR) begin
        if (load_start) begin
          m_mode = M_SYNC; m_csum = 8'h00; m_buf.delete(); m_words = 0;
        end
      end else if (xfer) begin
        if (m_mode == M_SYNC) begin
          if (byte_data == 8'hA5) m_mode = M_DATA;
        end else if (m_mode == M_DATA) begin
          m_csum = m_csum ^ byte_data;
          m_buf.push_back(byte_data);
          if (m_buf.size() == 4) begin
            m_we   = 1'b1;
            m_addr = ADDR_W'(m_words);
            m_din  = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            m_buf.delete();
            m_words++;
            if (m_words == DEPTH) m_mode = M_CHECK;
          end
        end else begin
          m_mode = (byte_data == m_csum) ? M_DONE : M_ERR;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge nres);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("byte_ready", 64'(byte_ready), 64'(accepting(m_mode)));
    chk("busy",       64'(busy),       64'(accepting(m_mode)));
    chk("done",       64'(done),       64'(m_mode == M_DONE));
    chk("error",      64'(error),      64'(m_mode == M_ERR));
    chk("bram_we",    64'(bram_we),    64'(m_we));
    chk("bram_addr",  64'(bram_addr),  64'(m_addr));
    chk("bram_din",   64'(bram_din),   64'(m_din));
    if (bram_we === 1'b1) begin
      log_addr.push_back(bram_addr);
      log_din.push_back(bram_din);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic int gap_of(input int maxg);
    return (maxg == 0) ? 0 : int'($urandom_range(0, maxg));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("handshake_timeout", 64'(ok), 64'(1));
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_stream(input bit garbage, input logic [7:0] last, input int maxg);
    if (garbage) begin
      send_byte(8'h00, gap_of(maxg));
      send_byte(8'hFF, gap_of(maxg));
    end
    send_byte(8'hA5, gap_of(maxg));
    for (int i = 1; i <= 16; i++) send_byte(8'(i), gap_of(maxg));
    send_byte(last, gap_of(maxg));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwrites"}, 64'(log_addr.size()), 64'(4));
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk({tag, "_addr"}, 64'(log_addr[i]), 64'(i));
      chk({tag, "_din"},  64'(log_din[i]),  64'(EXP_W[i]));
    end
    log_addr.delete();
    log_din.delete();
  endtask

  task automatic check_final(input string tag, input bit exp_done);
    chk({tag, "_done"},  64'(done),  64'(exp_done));
    chk({tag, "_error"}, 64'(error), 64'(!exp_done));
    chk({tag, "_busy"},  64'(busy),  64'(0));
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_ready", 64'(byte_ready), 64'(0));
    chk("rst_we",    64'(bram_we),    64'(0));
    chk("rst_addr",  64'(bram_addr),  64'(0));
    chk("rst_din",   64'(bram_din),   64'(0));
    nres = 1'b1;
    @(posedge clk); #1;

    // nominal load
    pulse_start();
    send_stream(1'b0, 8'h10, 0);
    check_final("nominal", 1'b1);
    chk("model_csum", 64'(m_csum), 64'(8'h10));
    check_log("nominal");

    // garbage ahead of sync
    pulse_start();
    send_stream(1'b1, 8'h10, 0);
    check_final("garbage", 1'b1);
    check_log("garbage");

    // bad checksum
    pulse_start();
    send_stream(1'b0, 8'h11, 0);
    check_final("badsum", 1'b0);
    check_log("badsum");

    // random stalls
    pulse_start();
    send_stream(1'b0, 8'h10, 3);
    check_final("stall", 1'b1);
    check_log("stall");

    // reset after the 6th data byte
    pulse_start();
    send_byte(8'hA5, 0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    nres = 1'b0;
    #1;
    chk("midrst_ready", 64'(byte_ready), 64'(0));
    chk("midrst_busy",  64'(busy),       64'(0));
    chk("midrst_done",  64'(done),       64'(0));
    chk("midrst_error", 64'(error),      64'(0));
    chk("midrst_we",    64'(bram_we),    64'(0));
    chk("midrst_addr",  64'(bram_addr),  64'(0));
    chk("midrst_din",   64'(bram_din),   64'(0));
    chk("midrst_writes", 64'(log_addr.size()), 64'(1));
    log_addr.delete();
    log_din.delete();
    @(posedge clk); #1;
    nres = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("postrst_idle", 64'(busy), 64'(0));
    pulse_start();
    send_stream(1'b0, 8'h10, 0);
    check_final("postrst", 1'b1);
    check_log("postrst");

    // load_start during DATA ignored, then restart from DONE
    pulse_start();
    send_byte(8'hA5, 0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    pulse_start();
    for (int i = 7; i <= 10; i++) send_byte(8'(i), 0);
    pulse_start();
    for (int i = 11; i <= 16; i++) send_byte(8'(i), 0);
    send_byte(8'h10, 0);
    repeat (2) begin @(posedge clk); #1; end
    check_final("ignore", 1'b1);
    check_log("ignore");
    pulse_start();
    chk("restart_done", 64'(done), 64'(0));
    chk("restart_busy", 64'(busy), 64'(1));
    send_stream(1'b0, 8'h10, 0);
    check_final("restart", 1'b1);
    check_log("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
